// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } dmem_state_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering, sign extension and alignment checks
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word_rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bad_funct3
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign shifted  = word_rdata >> {addr_lo, 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = addr_lo[1] ? word_rdata[31:16] : word_rdata[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_rep  = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_rep  = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: bad_funct3 = 1'b1;
        endcase
        // Unsigned sizes exist only for loads
        if (we && (funct3 == F3_BU || funct3 == F3_HU))
            bad_funct3 = 1'b1;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            F3_W:    load_data = word_rdata;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle RV32I load/store responder with error reporting
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [2:0]       lat_funct3;
    dmem_rsp_t        rsp_q;
    logic             accept;
    logic             do_access;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   word_rdata;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep;
    logic [31:0]   load_data;
    logic          misaligned;
    logic          bad_funct3;
    logic          out_of_range;
    logic          access_err;

    assign word_idx     = lat_addr[AW+1:2];
    assign word_rdata   = mem[word_idx];
    assign out_of_range = (lat_addr[31:2] >= 30'(DEPTH_WORDS));
    assign access_err   = bad_funct3 | misaligned | out_of_range;

    dmem_lane_align u_lane_align (
        .funct3     (lat_funct3),
        .we         (lat_we),
        .addr_lo    (lat_addr[1:0]),
        .wdata      (lat_wdata),
        .word_rdata (word_rdata),
        .byte_en    (byte_en),
        .wdata_rep  (wdata_rep),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bad_funct3 (bad_funct3)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        do_access  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    do_access  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_funct3 <= 3'b000;
            rsp_q      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
                cnt        <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                rsp_q.err   <= access_err;
                rsp_q.rdata <= (access_err || lat_we) ? 32'h0 : load_data;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (!rst && do_access && lat_we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[word_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
    endtask

    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int guard;
        int lat;
        @(negedge clk);
        drive_req(we, addr, wdata, f3);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'd2);
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
        check({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] held_rdata;
        int lat;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.req_ready", {31'h0, req_ready}, 32'h0);
        check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.req_ready", {31'h0, req_ready}, 32'h1);

        access("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        access("lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        access("lb_13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
        access("lbu_13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
        access("lh_12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
        access("lhu_10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);
        access("lb_10", 1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 1'b0);

        access("sb_11", 1'b1, 32'h11, 32'h00000011, 3'b000, 32'h0, 1'b0);
        access("sh_12", 1'b1, 32'h12, 32'h00002233, 3'b001, 32'h0, 1'b0);
        access("lw_merge", 1'b0, 32'h10, 32'h0, 3'b010, 32'h223311EF, 1'b0);

        access("err_lw_02", 1'b0, 32'h02, 32'h0, 3'b010, 32'h0, 1'b1);
        access("err_sh_01", 1'b1, 32'h11, 32'h0000AAAA, 3'b001, 32'h0, 1'b1);
        access("err_lw_oor", 1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1);
        access("err_sw_oor", 1'b1, 32'h1000, 32'h55555555, 3'b010, 32'h0, 1'b1);
        access("err_f3_011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        access("err_sbu", 1'b1, 32'h10, 32'h000000AA, 3'b100, 32'h0, 1'b1);
        access("lw_unchanged", 1'b0, 32'h10, 32'h0, 3'b010, 32'h223311EF, 1'b0);

        access("sw_last", 1'b1, 32'hFFC, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
        access("lw_last", 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

        // Backpressure: hold the response, keep a second request pending meanwhile
        @(negedge clk);
        drive_req(1'b0, 32'h10, 32'h0, 3'b010);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, 32'h11, 32'h0, 3'b100);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp.lat", 32'(lat), 32'd2);
        held_rdata = rsp_rdata;
        check("bp.rdata", held_rdata, 32'h223311EF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp.hold_rdata", rsp_rdata, 32'h223311EF);
            check("bp.hold_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp.after_valid", {31'h0, rsp_valid}, 32'h0);
        check("bp.after_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp.accepted", {31'h0, req_ready}, 32'h0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp2.lat", 32'(lat), 32'd2);
        check("bp2.rdata", rsp_rdata, 32'h00000011);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while a store waits: the store must be dropped
        access("sw_20", 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
        access("lw_20", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 32'h20, 32'h12345678, 3'b010);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort.req_ready", {31'h0, req_ready}, 32'h0);
        check("abort.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort.idle_valid", {31'h0, rsp_valid}, 32'h0);
        end
        check("abort.req_ready_post", {31'h0, req_ready}, 32'h1);
        check("abort.rsp_rdata", rsp_rdata, 32'h0);
        check("abort.rsp_err", {31'h0, rsp_err}, 32'h0);
        access("lw_20_kept", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
